corelet_ctrl: RTL
=================

// Module: corelet_ctrl
// PURPOSE
// Sequencer for one corelet pass (weight-stationary): fetches `col` weight vectors from
// activation/weight SRAM into L0, kernel-loads the MAC array, fetches `nij` activation
// vectors, executes, then drains the OFIFO into psum SRAM. Sits between the top-level
// testbench/host (start/cfg) and the corelet + xmem/pmem SRAMs.
// PARAMETERS
// row      8   MAC array rows (L0 lanes)
// col      8   MAC array columns (weight vectors per kernel load; OFIFO lanes)
// L0_DEPTH 64  L0 FIFO depth; max legal cfg_nij
// AW       11  SRAM address width
// PORTS
// clk          in   1      clock
// reset        in   1      asynchronous, active-low reset
// start        in   1      1-cycle pulse; begin a pass (ignored unless IDLE)
// cfg_nij      in   7      activation vectors this pass; sampled at start
// cfg_w_base   in   AW     xmem address of first weight vector; sampled at start
// cfg_x_base   in   AW     xmem address of first activation vector; sampled at start
// cfg_p_base   in   AW     pmem address of first psum write; sampled at start
// busy         out  1      high from accepted start until done
// done         out  1      1-cycle pulse at end of pass
// err          out  1      1-cycle pulse: start rejected (cfg_nij==0 or >L0_DEPTH)
// xmem_rd      out  1      xmem read enable; data valid next cycle
// xmem_addr    out  AW     xmem read address
// l0_wr        out  1      write xmem data into L0
// l0_rd        out  1      pop L0 row vector into array
// l0_full      in   1      L0 full
// l0_ready     in   1      L0 has data in every lane
// inst         out  2      {execute, kernel_load} to corelet
// ofifo_full   in   1      OFIFO full
// ofifo_valid  in   1      OFIFO holds a complete row
// ofifo_rd     out  1      pop OFIFO
// pmem_wr      out  1      write psum_out to pmem
// pmem_addr    out  AW     pmem write address
// BEHAVIOUR
// Reset (reset==0, async): state IDLE, all counters 0, every output 0.
// FSM: IDLE -> W_FILL -> W_LOAD -> W_FLUSH -> X_FILL -> X_EXEC -> DRAIN -> IDLE.
// IDLE: start with 1<=cfg_nij<=L0_DEPTH latches cfg, busy=1, -> W_FILL; else err=1, stay.
// W_FILL: xmem_rd=1 for exactly col cycles, addr cfg_w_base+k; l0_wr=xmem_rd delayed 1 cyc.
//   -> W_LOAD one cycle after last l0_wr. Issue paused while l0_full=1 (in-flight write
//   still completes); l0_wr with l0_full=1 never allowed (depth >= col guaranteed).
// W_LOAD: inst=2'b01 and l0_rd=1 together, only in cycles with l0_ready=1; col pops total.
// W_FLUSH: inst=00, l0_rd=0 for exactly row+col cycles (weight propagation).
// X_FILL: same as W_FILL with cfg_nij reads from cfg_x_base.
// X_EXEC: inst=2'b10 and l0_rd=1 together when l0_ready && !ofifo_full; else inst=00,
//   l0_rd=0 (stall, no pop lost). -> DRAIN after cfg_nij pops.
// DRAIN: ofifo_rd=ofifo_valid (combinational, same cycle). pmem_wr = ofifo_rd delayed
//   1 cycle; pmem_addr = cfg_p_base + write index. After cfg_nij pmem writes: done=1,
//   busy=0, -> IDLE (done and busy-drop same cycle).
// Counters: width clog2(L0_DEPTH+1); addresses wrap mod 2^AW (no saturation).
// Only one of inst[1:0] is ever 1; inst!=00 only with l0_rd=1.
// start while busy: ignored, no err. Reset mid-pass: immediate IDLE, outputs 0, no done.
// TESTING
// 1 Reset: hold reset=0, toggle inputs -> all outputs 0, busy=0.
// 2 Nominal: nij=4, bases w=0,x=16,p=32, L0/OFIFO always ready -> xmem addrs 0..7,
//   16..19; 8 inst=01 pops, 16 idle cycles, 4 inst=10 pops; pmem 32..35; one done.
// 3 OFIFO backpressure: ofifo_full=1 for 5 cycles mid X_EXEC -> inst=00, l0_rd=0 those
//   cycles; total execute pops still 4.
// 4 Bad cfg: start with nij=0, then nij=65 -> err pulse each, busy stays 0.
// 5 Start while busy and reset in X_EXEC -> second start ignored; reset forces IDLE,
//   no done; fresh start afterward completes normally.
// 6 Boundary nij=64, p_base=2^AW-2 -> 64 pmem writes, pmem_addr wraps to 0.

Source files
------------

// File: rtl/corelet_ctrl.sv
// Corelet pass sequencer: weight fill, kernel load, flush, activation fill,
// execute, then drain the OFIFO into psum memory.
module corelet_ctrl #(
  parameter int unsigned Row     = 8,
  parameter int unsigned Col     = 8,
  parameter int unsigned L0Depth = 64,
  parameter int unsigned Aw      = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [6:0]    cfg_nij_i,
  input  logic [Aw-1:0] cfg_w_base_i,
  input  logic [Aw-1:0] cfg_x_base_i,
  input  logic [Aw-1:0] cfg_p_base_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          xmem_rd_o,
  output logic [Aw-1:0] xmem_addr_o,
  output logic          l0_wr_o,
  output logic          l0_rd_o,
  input  logic          l0_full_i,
  input  logic          l0_ready_i,
  output logic [1:0]    inst_o,
  input  logic          ofifo_full_i,
  input  logic          ofifo_valid_i,
  output logic          ofifo_rd_o,
  output logic          pmem_wr_o,
  output logic [Aw-1:0] pmem_addr_o
);

  localparam int unsigned FlushLen = Row + Col;
  localparam int unsigned CntMax   = (L0Depth > FlushLen) ? L0Depth : FlushLen;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StWFill, StWLoad, StWFlush, StXFill, StXExec, StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] nij_q, nij_d;
  logic [Aw-1:0]   w_base_q, w_base_d, x_base_q, x_base_d, p_base_q, p_base_d;
  logic [CntW-1:0] cnt_q, cnt_d;   // reads issued / pops / flush cycles
  logic [CntW-1:0] wcnt_q, wcnt_d; // L0 writes or pmem writes completed
  logic            rd_q, prd_q, done_q, done_d, err_q, err_d;

  logic [CntW-1:0] fill_len;
  logic [Aw-1:0]   fill_base;
  logic            cfg_ok;

  assign fill_len  = (state_q == StXFill) ? nij_q : CntW'(Col);
  assign fill_base = (state_q == StXFill) ? x_base_q : w_base_q;
  assign cfg_ok    = (cfg_nij_i != 7'd0) && (32'(cfg_nij_i) <= L0Depth);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      nij_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      rd_q     <= 1'b0;
      prd_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nij_q    <= nij_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      rd_q     <= xmem_rd_o;
      prd_q    <= ofifo_rd_o;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d  = state_q;
    nij_d    = nij_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    p_base_d = p_base_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cfg_ok) begin
            nij_d    = CntW'(cfg_nij_i);
            w_base_d = cfg_w_base_i;
            x_base_d = cfg_x_base_i;
            p_base_d = cfg_p_base_i;
            cnt_d    = '0;
            wcnt_d   = '0;
            state_d  = StWFill;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWFill, StXFill: begin
        if (xmem_rd_o) cnt_d = cnt_q + CntW'(1);
        if (rd_q) begin
          wcnt_d = wcnt_q + CntW'(1);
          if (wcnt_q == fill_len - CntW'(1)) begin
            cnt_d   = '0;
            wcnt_d  = '0;
            state_d = (state_q == StWFill) ? StWLoad : StXExec;
          end
        end
      end
      StWLoad: begin
        if (l0_rd_o) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(Col - 1)) begin
            cnt_d   = '0;
            state_d = StWFlush;
          end
        end
      end
      StWFlush: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(FlushLen - 1)) begin
          cnt_d   = '0;
          state_d = StXFill;
        end
      end
      StXExec: begin
        if (l0_rd_o) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == nij_q - CntW'(1)) begin
            cnt_d   = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (ofifo_rd_o) cnt_d = cnt_q + CntW'(1);
        if (prd_q) begin
          wcnt_d = wcnt_q + CntW'(1);
          if (wcnt_q == nij_q - CntW'(1)) begin
            cnt_d   = '0;
            wcnt_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state, counters and handshake inputs
  always_comb begin
    busy_o      = (state_q != StIdle);
    done_o      = done_q;
    err_o       = err_q;
    xmem_rd_o   = 1'b0;
    xmem_addr_o = '0;
    l0_wr_o     = rd_q;
    l0_rd_o     = 1'b0;
    inst_o      = 2'b00;
    ofifo_rd_o  = 1'b0;
    pmem_wr_o   = prd_q;
    pmem_addr_o = prd_q ? (p_base_q + Aw'(wcnt_q)) : '0;
    case (state_q)
      StWFill, StXFill: begin
        // An in-flight read still lands in L0 while issue pauses on full.
        xmem_rd_o = (cnt_q < fill_len) && !l0_full_i;
        if (xmem_rd_o) xmem_addr_o = fill_base + Aw'(cnt_q);
      end
      StWLoad: begin
        if (l0_ready_i) begin
          l0_rd_o = 1'b1;
          inst_o  = 2'b01;
        end
      end
      StXExec: begin
        if (l0_ready_i && !ofifo_full_i) begin
          l0_rd_o = 1'b1;
          inst_o  = 2'b10;
        end
      end
      StDrain: begin
        ofifo_rd_o = ofifo_valid_i && (cnt_q < nij_q);
      end
      default: ;
    endcase
  end

endmodule
